// File: rtl/result_serializer.sv
// Streams a snapshot of the 3x3 result matrix as a framed byte stream:
// SYNC byte, 3 little-endian bytes per element, then an XOR checksum byte.
module result_serializer #(
  parameter int          NUM_ELEM  = 9,
  parameter int          ELEM_W    = 18,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_ELEM*ELEM_W-1:0]   c_flat,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  output logic                         done
);

  localparam int NB    = 3 * NUM_ELEM;
  localparam int IDX_W = $clog2(NB + 2);
  // idx is the position of the byte on out_data: 0 = SYNC, 1..NB = data, NB+1 = checksum
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);
  localparam logic [IDX_W-1:0] CSUM_PRE = IDX_W'(NB);

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [7:0]                   checksum;
  logic [NUM_ELEM*ELEM_W-1:0]   snapshot;

  logic [7:0]                   data_bytes [NB];
  logic [7:0]                   csum_acc;
  logic [7:0]                   next_byte;

  always_comb begin
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      data_bytes[3*k]   = snapshot[k*ELEM_W +: 8];
      data_bytes[3*k+1] = snapshot[k*ELEM_W+8 +: 8];
      data_bytes[3*k+2] = '0;
      data_bytes[3*k+2][ELEM_W-17:0] = snapshot[k*ELEM_W+16 +: ELEM_W-16];
    end
  end

  // SYNC (idx 0) is excluded from the checksum; data byte idx maps to data_bytes[idx-1],
  // so the byte to present after accepting idx is data_bytes[idx].
  always_comb begin
    csum_acc  = (idx != '0) ? (checksum ^ out_data) : checksum;
    next_byte = (idx == CSUM_PRE) ? csum_acc : data_bytes[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      checksum  <= '0;
      snapshot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (enable) begin
            snapshot  <= c_flat;
            out_data  <= SYNC_BYTE;
            out_valid <= 1'b1;
            idx       <= '0;
            checksum  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!enable) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
          end else if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= FINISH;
              out_valid <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              checksum <= csum_acc;
              out_data <= next_byte;
            end
          end
        end
        FINISH: begin
          done <= 1'b0;
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: frames are collected byte by byte on
// accepted cycles and compared against hand-computed and model-built frames.
module tb_result_serializer;

  localparam int NUM_ELEM = 9;
  localparam int ELEM_W   = 18;
  localparam int CW       = NUM_ELEM * ELEM_W;
  localparam int FRAME    = 3 * NUM_ELEM + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] c_flat;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [64];
  logic [7:0] exp [FRAME];
  int got_n, done_cnt, first_v, done_cyc;

  result_serializer #(.NUM_ELEM(NUM_ELEM), .ELEM_W(ELEM_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .c_flat(c_flat),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  task automatic build_exp(input logic [CW-1:0] c);
    logic [ELEM_W-1:0] e;
    logic [7:0] x;
    x = 8'h00;
    exp[0] = 8'hA5;
    for (int k = 0; k < NUM_ELEM; k++) begin
      e = c[k*ELEM_W +: ELEM_W];
      exp[3*k+1] = e[7:0];
      exp[3*k+2] = e[15:8];
      exp[3*k+3] = {6'b0, e[17:16]};
      x = x ^ e[7:0] ^ e[15:8] ^ {6'b0, e[17:16]};
    end
    exp[FRAME-1] = x;
  endtask

  // Runs one frame. stall_at: byte index to hold out_ready low for 3 cycles (-1 none).
  // abort_at: byte index at which enable drops or reset rises (-1 none).
  task automatic run_frame(input int stall_at, input bit chg, input int abort_at, input bit use_rst);
    int stalls;
    got_n = 0; done_cnt = 0; first_v = -1; done_cyc = -1; stalls = 0;
    out_ready = 1'b1;
    enable = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (chg && cyc == 0) c_flat = '1;
      chk("valid_done_excl", {31'b0, out_valid & done}, 32'd0);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc)
        chk("finish_hold", {31'b0, out_valid}, 32'd0);
      if (abort_at >= 0 && got_n == abort_at && out_valid) begin
        if (use_rst) reset = 1'b1; else enable = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_data", {24'b0, out_data}, 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
          chk("abort_no_done", {31'b0, done}, 32'd0);
          @(negedge clk);
        end
        return;
      end
      out_ready = !(stall_at >= 0 && got_n == stall_at && stalls < 3);
      if (!out_ready && out_valid) begin
        stalls++;
        chk("stall_data", {24'b0, out_data}, {24'b0, exp[got_n]});
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready && got_n < 64) begin
        got[got_n] = out_data;
        got_n++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    chk("done_seen", {31'b0, done_cyc >= 0}, 32'd1);
    chk("done_once", done_cnt, 32'd1);
    enable = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, got_n, FRAME);
    for (int i = 0; i < FRAME; i++)
      chk($sformatf("%s_b%0d", tag, i), {24'b0, got[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b1; c_flat = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {24'b0, out_data}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: all zero, latency and frame length
    c_flat = '0;
    build_exp(c_flat);
    run_frame(-1, 1'b0, -1, 1'b0);
    chk("t1_latency", first_v, 32'd0);
    chk("t1_span", done_cyc - first_v, 32'd29);
    chk("t1_csum", {24'b0, got[28]}, 32'h00);
    cmp_frame("t1");

    // 2: C0 = 12345
    c_flat = '0;
    c_flat[0 +: ELEM_W] = 18'h12345;
    build_exp(c_flat);
    run_frame(-1, 1'b0, -1, 1'b0);
    chk("t2_b1", {24'b0, got[1]}, 32'h45);
    chk("t2_b2", {24'b0, got[2]}, 32'h23);
    chk("t2_b3", {24'b0, got[3]}, 32'h01);
    chk("t2_csum", {24'b0, got[28]}, 32'h67);
    cmp_frame("t2");

    // 3: C8 = 3FFFF
    c_flat = '0;
    c_flat[8*ELEM_W +: ELEM_W] = 18'h3FFFF;
    build_exp(c_flat);
    run_frame(-1, 1'b0, -1, 1'b0);
    chk("t3_b25", {24'b0, got[25]}, 32'hFF);
    chk("t3_b26", {24'b0, got[26]}, 32'hFF);
    chk("t3_b27", {24'b0, got[27]}, 32'h03);
    chk("t3_csum", {24'b0, got[28]}, 32'h03);
    cmp_frame("t3");

    // 4: backpressure on byte 45
    c_flat = '0;
    c_flat[0 +: ELEM_W] = 18'h12345;
    build_exp(c_flat);
    run_frame(1, 1'b0, -1, 1'b0);
    chk("t4_span", done_cyc - first_v, 32'd32);
    chk("t4_csum", {24'b0, got[28]}, 32'h67);
    cmp_frame("t4");

    // 5: inputs change after capture
    c_flat = '0;
    c_flat[0 +: ELEM_W] = 18'h12345;
    build_exp(c_flat);
    run_frame(-1, 1'b1, -1, 1'b0);
    cmp_frame("t5");

    // 6: enable drop after 5 bytes, then a fresh frame
    c_flat = '0;
    c_flat[0 +: ELEM_W] = 18'h12345;
    c_flat[1*ELEM_W +: ELEM_W] = 18'h2ABCD;
    build_exp(c_flat);
    run_frame(-1, 1'b0, 5, 1'b0);
    run_frame(-1, 1'b0, -1, 1'b0);
    chk("t6_b0", {24'b0, got[0]}, 32'hA5);
    cmp_frame("t6a");

    // 6b: reset mid-frame, then a fresh frame
    run_frame(-1, 1'b0, 10, 1'b1);
    run_frame(-1, 1'b0, -1, 1'b0);
    chk("t6r_b0", {24'b0, got[0]}, 32'hA5);
    cmp_frame("t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
